// File: rtl/uart_rx_frontend_if.sv
// Receive-side handshake between the UART front-end and its consumer (LCD writer).
interface uart_rx_frontend_if;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_err;
  logic       RxD_busy;

  modport master (output RxD_data, RxD_data_ready, RxD_frame_err, RxD_busy);
  modport slave  (input  RxD_data, RxD_data_ready, RxD_frame_err, RxD_busy);
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchronizes RxD, samples mid-bit, emits good bytes with a one-cycle strobe.
//
// state     | meaning
// WAIT_IDLE | after reset / framing error, wait for a genuinely high line
// IDLE      | line idle, waiting for a falling edge
// START     | timing to mid start bit, rejecting glitches
// DATA      | sampling 8 data bits LSB first
// STOP      | sampling stop bit, deliver byte or flag framing error
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RxD,
  uart_rx_frontend_if.master  rx
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rx_s;
  logic [1:0]  prime;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  data_q, data_nxt;
  logic        ready_q, ready_nxt;
  logic        ferr_q, ferr_nxt;
  logic        busy_q, busy_nxt;

  // The synchronizer's reset value is not a line sample; prime marks when rx_s reflects RxD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      prime   <= 2'b00;
    end else begin
      rx_meta <= RxD;
      rx_s    <= rx_meta;
      prime   <= {prime[0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    ready_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      WAIT_IDLE: begin
        cnt_nxt = '0;
        if (prime[1] && rx_s) state_nxt = IDLE;
      end
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rx_s;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shreg;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
    // Busy stays up through the strobe cycle so it falls the cycle after.
    busy_nxt = (state_nxt == START) || (state_nxt == DATA) || (state_nxt == STOP) ||
               ready_nxt || ferr_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= WAIT_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      data_q  <= data_nxt;
      ready_q <= ready_nxt;
      ferr_q  <= ferr_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign rx.RxD_data       = data_q;
  assign rx.RxD_data_ready = ready_q;
  assign rx.RxD_frame_err  = ferr_q;
  assign rx.RxD_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: expected-strobe queue model plus literal checks.
module tb_uart_rx_frontend;
  localparam int N  = 16;
  localparam int H  = N / 2;
  localparam int NB = 434;
  localparam int LAT   = 2 + H + 9 * N;
  localparam int LAT_B = 2 + NB / 2 + 9 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;

  uart_rx_frontend_if ifa ();
  uart_rx_frontend_if ifb ();

  uart_rx_frontend #(.CLKS_PER_BIT(N)) dut_a (
    .clk(clk), .rst(rst), .RxD(rxd_a), .rx(ifa.master)
  );
  uart_rx_frontend #(.CLKS_PER_BIT(NB)) dut_b (
    .clk(clk), .rst(rst), .RxD(rxd_b), .rx(ifb.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } ev_t;
  ev_t exp_q[$];

  logic [7:0] model_data = 8'h00;
  bit  chk_en    = 1'b0;
  bit  busy_next = 1'b0;
  int  ready_cnt = 0;
  int  ferr_cnt  = 0;
  int  ready_cycs[$];

  int c0, rc, fc, bc, lat, ferr_b;
  logic [7:0] fb;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit expect_ev);
    ev_t ev;
    if (expect_ev) begin
      ev.is_err = !stop;
      ev.data   = b;
      ev.due    = cyc + LAT;
      exp_q.push_back(ev);
    end
    rxd_a = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rxd_a = b[i];
      tick(N);
    end
    rxd_a = stop;
    tick(N);
  endtask

  task automatic apply_reset(input int n);
    chk_en = 1'b0;
    rst    = 1'b0;
    tick(n);
    rst        = 1'b1;
    model_data = 8'h00;
    exp_q.delete();
    busy_next  = 1'b0;
    chk_en     = 1'b1;
  endtask

  // Every-cycle comparison against the expected-strobe queue.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].due + 2) begin
        checks++;
        errors++;
        $display("FAIL strobe_timeout: no strobe by cycle %0d, expected near %0d (data 0x%0h)",
                 cyc, exp_q[0].due, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (ifa.RxD_data_ready || ifa.RxD_frame_err) begin
        ev_t ev;
        check("strobe_mutex", int'(ifa.RxD_data_ready && ifa.RxD_frame_err), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: ready=%0d ferr=%0d data=0x%0h at cycle %0d, expected none",
                   ifa.RxD_data_ready, ifa.RxD_frame_err, ifa.RxD_data, cyc);
        end else begin
          ev = exp_q.pop_front();
          check("strobe_kind", int'(ifa.RxD_frame_err), int'(ev.is_err));
          check_range("strobe_latency", cyc, ev.due - 2, ev.due + 2);
          if (!ev.is_err) model_data = ev.data;
        end
        check("busy_on_strobe", int'(ifa.RxD_busy), 1);
        busy_next = 1'b1;
        if (ifa.RxD_data_ready) begin
          ready_cnt++;
          ready_cycs.push_back(cyc);
        end else begin
          ferr_cnt++;
        end
      end else if (busy_next) begin
        check("busy_after_strobe", int'(ifa.RxD_busy), 0);
        busy_next = 1'b0;
      end
      check("data_hold", int'(ifa.RxD_data), int'(model_data));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    apply_reset(2);
    @(negedge clk);
    check("reset_data",  int'(ifa.RxD_data), 8'h00);
    check("reset_ready", int'(ifa.RxD_data_ready), 0);
    check("reset_ferr",  int'(ifa.RxD_frame_err), 0);
    check("reset_busy",  int'(ifa.RxD_busy), 0);
    tick(10);

    // single byte
    ready_cycs.delete();
    c0 = cyc;
    send_frame(8'h41, 1'b1, 1'b1);
    tick(20);
    check("single_ready_count", ready_cnt, 1);
    check("single_data", int'(ifa.RxD_data), 8'h41);
    check("single_no_ferr", ferr_cnt, 0);
    if (ready_cycs.size() > 0) check_range("single_latency", ready_cycs[0] - c0, 152, 156);

    // back-to-back, zero idle gap
    ready_cycs.delete();
    rc = ready_cnt;
    send_frame(8'h0D, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    tick(30);
    check("b2b_ready_count", ready_cnt - rc, 3);
    if (ready_cycs.size() == 3) begin
      check("b2b_spacing_1", ready_cycs[1] - ready_cycs[0], 160);
      check("b2b_spacing_2", ready_cycs[2] - ready_cycs[1], 160);
    end
    check("b2b_last_data", int'(ifa.RxD_data), 8'hFF);

    // glitch
    rc = ready_cnt;
    fc = ferr_cnt;
    bc = 0;
    for (int i = 0; i < 44; i++) begin
      rxd_a = (i < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (ifa.RxD_busy) bc++;
      @(posedge clk);
      #1;
    end
    check_range("glitch_busy_cycles", bc, 0, 10);
    check("glitch_busy_end", int'(ifa.RxD_busy), 0);
    check("glitch_no_ready", ready_cnt - rc, 0);
    check("glitch_no_ferr", ferr_cnt - fc, 0);
    send_frame(8'h30, 1'b1, 1'b1);
    tick(20);
    check("after_glitch_data", int'(ifa.RxD_data), 8'h30);

    // framing error
    tick(16);
    send_frame(8'h41, 1'b1, 1'b1);
    rc = ready_cnt;
    fc = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    rxd_a = 1'b0;
    tick(48);
    check("ferr_count", ferr_cnt - fc, 1);
    check("ferr_no_ready", ready_cnt - rc, 0);
    check("ferr_data_kept", int'(ifa.RxD_data), 8'h41);
    rxd_a = 1'b1;
    tick(32);
    send_frame(8'h31, 1'b1, 1'b1);
    tick(20);
    check("after_ferr_data", int'(ifa.RxD_data), 8'h31);

    // reset mid-frame: reset right after data bit 3 of 0xC3
    fb = 8'hC3;
    rc = ready_cnt;
    fc = ferr_cnt;
    rxd_a = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rxd_a = fb[i];
      tick(N);
    end
    rxd_a = fb[4];
    apply_reset(2);
    @(negedge clk);
    check("midrst_data",  int'(ifa.RxD_data), 8'h00);
    check("midrst_ready", int'(ifa.RxD_data_ready), 0);
    check("midrst_ferr",  int'(ifa.RxD_frame_err), 0);
    check("midrst_busy",  int'(ifa.RxD_busy), 0);
    tick(1);
    tick(N - 3);
    for (int i = 5; i < 8; i++) begin
      rxd_a = fb[i];
      tick(N);
    end
    rxd_a = 1'b1;
    tick(N);
    tick(32);
    check("midrst_no_ready", ready_cnt - rc, 0);
    check("midrst_no_ferr", ferr_cnt - fc, 0);
    send_frame(8'h7E, 1'b1, 1'b1);
    tick(20);
    check("after_midrst_data", int'(ifa.RxD_data), 8'h7E);

    // reset with line held low
    rc = ready_cnt;
    fc = ferr_cnt;
    rxd_a = 1'b0;
    apply_reset(2);
    bc = 0;
    repeat (100) begin
      @(negedge clk);
      if (ifa.RxD_busy) bc++;
      tick(1);
    end
    check("lowrst_busy_cycles", bc, 0);
    check("lowrst_no_ready", ready_cnt - rc, 0);
    check("lowrst_no_ferr", ferr_cnt - fc, 0);
    rxd_a = 1'b1;
    tick(20);
    send_frame(8'h20, 1'b1, 1'b1);
    tick(20);
    check("after_lowrst_data", int'(ifa.RxD_data), 8'h20);

    // one frame at 434 clocks per bit
    fb = 8'h41;
    c0 = cyc;
    lat = -1;
    ferr_b = 0;
    fork
      begin
        rxd_b = 1'b0;
        tick(NB);
        for (int i = 0; i < 8; i++) begin
          rxd_b = fb[i];
          tick(NB);
        end
        rxd_b = 1'b1;
        tick(NB);
      end
      begin
        for (int k = 0; k < 4600 && lat < 0; k++) begin
          @(negedge clk);
          if (ifb.RxD_data_ready) lat = cyc - c0;
          if (ifb.RxD_frame_err) ferr_b++;
        end
      end
    join
    check_range("latency_434", lat, LAT_B - 2, LAT_B + 2);
    check("data_434", int'(ifb.RxD_data), 8'h41);
    check("no_ferr_434", ferr_b, 0);

    tick(5);
    check("pending_strobes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
